// File: rtl/simple_alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one combinational ALU between NUM_REQ lanes,
// with an issue register (S1) feeding the ALU and a writeback register (S2) behind it.

`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 3
`endif

module simple_alu_issue_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int SIZE_TAG = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ*`SIZE_OPCODE_I-1:0]    req_opcode_i,
  input  logic [NUM_REQ*`SIZE_DATA-1:0]        req_data1_i,
  input  logic [NUM_REQ*`SIZE_DATA-1:0]        req_data2_i,
  input  logic [NUM_REQ*`SIZE_IMMEDIATE-1:0]   req_immd_i,
  input  logic [NUM_REQ*SIZE_TAG-1:0]          req_tag_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  output logic [`SIZE_DATA-1:0]                alu_data1_o,
  output logic [`SIZE_DATA-1:0]                alu_data2_o,
  output logic [`SIZE_IMMEDIATE-1:0]           alu_immd_o,
  output logic [`SIZE_OPCODE_I-1:0]            alu_opcode_o,
  input  logic [`SIZE_DATA-1:0]                alu_result_i,
  input  logic [`EXECUTION_FLAGS-1:0]          alu_flags_i,
  output logic                                 wb_valid_o,
  output logic [SIZE_TAG-1:0]                  wb_tag_o,
  output logic [`SIZE_DATA-1:0]                wb_result_o,
  output logic [`EXECUTION_FLAGS-1:0]          wb_flags_o,
  output logic [1:0]                           wb_lane_o,
  input  logic                                 wb_ready_i
);

  localparam int OPW = `SIZE_OPCODE_I;
  localparam int DW  = `SIZE_DATA;
  localparam int IW  = `SIZE_IMMEDIATE;

  // Handshake: a lane transfers at a rising edge where req_valid_i[i] and
  // req_ready_o[i] are both high; the writeback entry transfers where
  // wb_valid_o and wb_ready_i are both high. Neither side may depend on the
  // other's ready/valid combinationally beyond the stall chain below.

  logic            s1_valid;
  logic [OPW-1:0]  s1_opcode;
  logic [DW-1:0]   s1_data1;
  logic [DW-1:0]   s1_data2;
  logic [IW-1:0]   s1_immd;
  logic [SIZE_TAG-1:0] s1_tag;
  logic [1:0]      s1_lane;
  logic [1:0]      rr_ptr;

  logic            s2_adv;
  logic            s1_adv;
  logic            grant_en;
  logic            found;
  logic            accept;
  logic [1:0]      winner;
  logic [1:0]      cand;
  logic [1:0]      rr_next;
  logic [3:0]      valid_ext;
  logic [3:0]      grant_ext;

  logic [OPW-1:0]      sel_opcode;
  logic [DW-1:0]       sel_data1;
  logic [DW-1:0]       sel_data2;
  logic [IW-1:0]       sel_immd;
  logic [SIZE_TAG-1:0] sel_tag;

  function automatic logic [1:0] wrap_lane(input logic [1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return 2'(sum);
  endfunction

  assign s2_adv    = !wb_valid_o || wb_ready_i;
  assign s1_adv    = !s1_valid || s2_adv;
  assign grant_en  = s1_adv && !flush_i && !reset;
  assign valid_ext = 4'(req_valid_i);

  // Scan from rr_ptr upward, wrapping at NUM_REQ; the first valid lane wins.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    cand   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_lane(rr_ptr, k);
      if (!found && valid_ext[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant_ext = 4'd0;
    if (found && grant_en) grant_ext[winner] = 1'b1;
  end

  assign req_ready_o = grant_ext[NUM_REQ-1:0];
  assign accept      = found && grant_en;
  assign rr_next     = (winner == 2'(NUM_REQ - 1)) ? 2'd0 : winner + 2'd1;

  always_comb begin
    sel_opcode = '0;
    sel_data1  = '0;
    sel_data2  = '0;
    sel_immd   = '0;
    sel_tag    = '0;
    for (int l = 0; l < NUM_REQ; l++) begin
      if (winner == 2'(l)) begin
        sel_opcode = req_opcode_i[l*OPW +: OPW];
        sel_data1  = req_data1_i[l*DW +: DW];
        sel_data2  = req_data2_i[l*DW +: DW];
        sel_immd   = req_immd_i[l*IW +: IW];
        sel_tag    = req_tag_i[l*SIZE_TAG +: SIZE_TAG];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_opcode   <= '0;
      s1_data1    <= '0;
      s1_data2    <= '0;
      s1_immd     <= '0;
      s1_tag      <= '0;
      s1_lane     <= 2'd0;
      rr_ptr      <= 2'd0;
      wb_valid_o  <= 1'b0;
      wb_tag_o    <= '0;
      wb_result_o <= '0;
      wb_flags_o  <= '0;
      wb_lane_o   <= 2'd0;
    end else if (flush_i) begin
      // Squash both stages; data fields are don't-care once valid drops.
      s1_valid   <= 1'b0;
      wb_valid_o <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_opcode <= sel_opcode;
        s1_data1  <= sel_data1;
        s1_data2  <= sel_data2;
        s1_immd   <= sel_immd;
        s1_tag    <= sel_tag;
        s1_lane   <= winner;
        rr_ptr    <= rr_next;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv) begin
        wb_valid_o  <= s1_valid;
        wb_tag_o    <= s1_tag;
        wb_lane_o   <= s1_lane;
        wb_result_o <= alu_result_i;
        wb_flags_o  <= alu_flags_i;
      end
    end
  end

  assign alu_opcode_o = s1_opcode;
  assign alu_data1_o  = s1_data1;
  assign alu_data2_o  = s1_data2;
  assign alu_immd_o   = s1_immd;

endmodule

// File: doc/simple_alu_issue_arbiter.md
Name: simple_alu_issue_arbiter

Overview:
- Shares one Simple ALU between NUM_REQ issue lanes using round-robin arbitration.
- Registers the granted operands into an issue stage that drives the ALU. Captures the ALU result into a writeback stage with valid/ready backpressure.
- Sits between the issue-queue select logic and the register-file writeback and bypass network.

Parameters:
- NUM_REQ, 2, number of requesting lanes (legal range 2..4).
- SIZE_TAG, 7, width of the destination physical-register tag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  squash all in-flight ops (branch mispredict recovery).
- req_valid_i  in  NUM_REQ  per-lane request valid.
- req_opcode_i  in  NUM_REQ*`SIZE_OPCODE_I  packed opcodes; lane i occupies slice i.
- req_data1_i  in  NUM_REQ*`SIZE_DATA  packed source operand 1.
- req_data2_i  in  NUM_REQ*`SIZE_DATA  packed source operand 2.
- req_immd_i  in  NUM_REQ*`SIZE_IMMEDIATE  packed immediates.
- req_tag_i  in  NUM_REQ*SIZE_TAG  packed destination tags.
- req_ready_o  out  NUM_REQ  one-hot grant; the request is accepted at the clock edge where valid and ready are both high.
- alu_data1_o  out  `SIZE_DATA  ALU data1 operand, driven from the issue register.
- alu_data2_o  out  `SIZE_DATA  ALU data2 operand.
- alu_immd_o  out  `SIZE_IMMEDIATE  ALU immediate.
- alu_opcode_o  out  `SIZE_OPCODE_I  ALU opcode.
- alu_result_i  in  `SIZE_DATA  ALU result_o.
- alu_flags_i  in  `EXECUTION_FLAGS  ALU flags_o.
- wb_valid_o  out  1  writeback entry valid.
- wb_tag_o  out  SIZE_TAG  destination tag.
- wb_result_o  out  `SIZE_DATA  result.
- wb_flags_o  out  `EXECUTION_FLAGS  execution flags.
- wb_lane_o  out  2  originating lane index.
- wb_ready_i  in  1  writeback consumer ready.

Behaviour:
- Two pipeline registers:
  - S1 (issue): s1_valid, opcode, data1, data2, immd, tag, lane.
  - S2 (writeback): wb_* outputs.
- ALU is combinational between S1 and S2. The ALU inputs are driven directly from S1 fields.
- Reset values:
  - s1_valid=0 and wb_valid_o=0.
  - All S1 and S2 data fields=0, so alu_*_o=0 and wb_tag_o/result/flags/lane=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready_o=0 during the reset cycle.
- Stall chain (combinational):
  - s2_adv = !wb_valid_o | wb_ready_i.
  - s1_adv = !s1_valid | s2_adv.
- Arbitration:
  - Scan lanes starting at rr_ptr, wrapping modulo NUM_REQ. The first lane with req_valid_i set is the winner.
  - req_ready_o[winner] = s1_adv & !flush_i & !reset. All other bits are 0.
  - At most one bit of req_ready_o is high per cycle.
- Acceptance: on an edge with an accepted request:
  - S1 loads the winner's slices, s1_valid=1, lane=winner.
  - rr_ptr = (winner+1) mod NUM_REQ.
  - If no request is accepted, rr_ptr holds.
- S1 advance: if s1_adv and no accept, s1_valid becomes 0. S1 data fields hold (don't-care).
- S2 capture: if s2_adv, S2 loads:
  - wb_valid_o = s1_valid;
  - tag and lane from S1;
  - result and flags from alu_result_i / alu_flags_i.
- S2 hold: if !s2_adv, S2 holds all fields and S1 holds all fields. The ALU re-evaluates the same S1 operands, so the result stays stable.
- Latency: accept at edge N -> op in S1 during cycle N..N+1 -> wb_valid_o=1 after edge N+1. That is 2 cycles request-to-writeback with no stall.
- Throughput: 1 op/cycle with wb_ready_i held at 1.
- Backpressure depth: with wb_ready_i=0, at most 2 ops are buffered (S1 plus S2). req_ready_o then drops to 0.
- wb_* outputs stay stable while wb_valid_o & !wb_ready_i.
- Flush, on the edge where flush_i=1:
  - s1_valid=0 and wb_valid_o=0.
  - No request is accepted that cycle.
  - rr_ptr holds.
- Flush takes priority over acceptance and capture. Reset takes priority over flush.
- Simultaneous flush and wb_ready_i: the S2 entry is dropped, not handed off. The consumer must qualify with flush_i, as the writeback stage does today.
- Reset mid-operation: all in-flight ops are lost. State returns to the reset values listed above.
- NOP opcode passes through like any other op. flags come from the ALU; no special casing.

Test Plan:
- Single lane 0 ADD, data1=5, data2=7, tag=0x12, wb_ready_i=1 -> req_ready_o=01 the same cycle; 2 cycles later wb_valid_o=1, wb_result_o=12, wb_tag_o=0x12, wb_lane_o=0.
- Both lanes valid continuously, wb_ready_i=1 -> grants alternate 01,10,01,10; writeback lanes alternate 0,1,0,1 with one result per cycle.
- Lane 1 ORI data1=0xF0, immd=0x0F while wb_ready_i=0 -> wb_valid_o=1 with result 0xFF held stable; after 2 accepts req_ready_o=00; raising wb_ready_i releases the entries in order.
- Ops in S1 and S2, flush_i=1 for one cycle -> next cycle wb_valid_o=0 and s1_valid=0; no accept during the flush cycle; rr_ptr unchanged.
- reset asserted with 2 ops buffered -> next cycle all outputs 0; first post-reset grant goes to lane 0 when both lanes are valid.
- Back-to-back dependent-free SUB 3-5 then SLTU 3<5 -> wb_result_o=0xFFFFFFFE, then 1, on consecutive cycles.
